// File: rtl/parking_logic_sched_if.sv
// Gate-sensor / hour-clock side and display/barrier side of the parking scheduler.
// The master drives the events and the hour. The slave (the scheduler) drives the counts and
// the status pulses.
interface parking_logic_sched_if #(
  parameter int unsigned CNT_W = 10
);
  // Gate events and hour clock
  logic             car_entered;
  logic             is_uni_car_entered;
  logic             car_exited;
  logic             is_uni_car_exited;
  logic [4:0]       hour;

  // Occupancy and free-space view
  logic [CNT_W-1:0] uni_parked_car;
  logic [CNT_W-1:0] parked_car;
  logic [CNT_W-1:0] uni_spill_car;
  logic [CNT_W-1:0] uni_vacated_space;
  logic [CNT_W-1:0] vacated_space;
  logic             uni_is_vacated_space;
  logic             is_vacated_space;

  // Per-event status
  logic             entry_ack;
  logic             entry_reject;
  logic             exit_err;
  logic             hour_err;

  modport master (
    output car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, hour,
    input  uni_parked_car, parked_car, uni_spill_car, uni_vacated_space, vacated_space,
    input  uni_is_vacated_space, is_vacated_space,
    input  entry_ack, entry_reject, exit_err, hour_err
  );

  modport slave (
    input  car_entered, is_uni_car_entered, car_exited, is_uni_car_exited, hour,
    output uni_parked_car, parked_car, uni_spill_car, uni_vacated_space, vacated_space,
    output uni_is_vacated_space, is_vacated_space,
    output entry_ack, entry_reject, exit_err, hour_err
  );
endinterface

// File: rtl/parking_logic_sched.sv
// Parking lot occupancy scheduler.
// The lot has a university reservation whose size depends on the hour, and the rest of the
// lot forms a general pool. University cars may spill into the general pool. When the
// reservation shrinks below the number of cars already in it, those cars stay where they are
// and use up general space instead.
module parking_logic_sched #(
  parameter int unsigned TOTAL_CAP    = 700,
  parameter int unsigned UNI_CAP_MAX  = 500,
  parameter int unsigned UNI_CAP_MIN  = 200,
  parameter int unsigned UNI_STEP     = 100,
  parameter int unsigned SHRINK_START = 13,
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned SPILL_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_logic_sched_if.slave  bus
);

  // Two spare bits so that summing three counters cannot wrap.
  localparam int unsigned WW = CNT_W + 2;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [WW-1:0]    wide_t;

  // State
  cnt_t       uni_res_cnt_q,   uni_res_cnt_d;
  cnt_t       uni_spill_cnt_q, uni_spill_cnt_d;
  cnt_t       gen_cnt_q,       gen_cnt_d;
  logic [4:0] hour_q,          hour_d;
  logic       hour_err_q,      hour_err_d;
  logic       entry_ack_q,     entry_ack_d;
  logic       entry_reject_q,  entry_reject_d;
  logic       exit_err_q,      exit_err_d;

  // Derived capacity and free-space values
  logic [31:0] red;
  cnt_t        uni_cap;
  wide_t       cap_w, gen_cap_w, excess_w, used_w;
  wide_t       res_w, spill_w, gen_w;
  cnt_t        uni_vac, gen_vac;
  logic        uni_free, gen_free;

  // Per-counter increment/decrement requests
  logic res_inc, res_dec, spill_inc, spill_dec, gen_inc, gen_dec;

  // Hour is clamped to the last valid hour; the error flag is registered with it.
  always_comb begin
    hour_err_d = (bus.hour > 5'd23);
    hour_d     = hour_err_d ? 5'd23 : bus.hour;
  end

  // Reservation size for the registered hour, shrinking stepwise down to the floor.
  always_comb begin
    red     = '0;
    uni_cap = cnt_t'(UNI_CAP_MAX);
    if (32'(hour_q) >= SHRINK_START) begin
      red = (32'(hour_q) - SHRINK_START + 32'd1) * UNI_STEP;
      if (red + UNI_CAP_MIN >= UNI_CAP_MAX) begin
        uni_cap = cnt_t'(UNI_CAP_MIN);
      end else begin
        uni_cap = cnt_t'(UNI_CAP_MAX - red);
      end
    end
  end

  // Free space in each pool. All subtractions saturate at zero.
  always_comb begin
    cap_w     = wide_t'(uni_cap);
    res_w     = wide_t'(uni_res_cnt_q);
    spill_w   = wide_t'(uni_spill_cnt_q);
    gen_w     = wide_t'(gen_cnt_q);
    gen_cap_w = (wide_t'(TOTAL_CAP) > cap_w) ? (wide_t'(TOTAL_CAP) - cap_w) : '0;
    // Reserved cars beyond a shrunken reservation occupy general spaces.
    excess_w  = (res_w > cap_w) ? (res_w - cap_w) : '0;
    used_w    = gen_w + spill_w + excess_w;
    uni_vac   = (cap_w > res_w) ? cnt_t'(cap_w - res_w) : '0;
    gen_vac   = (gen_cap_w > used_w) ? cnt_t'(gen_cap_w - used_w) : '0;
    uni_free  = (uni_vac != '0);
    gen_free  = (gen_vac != '0);
  end

  // Entry and exit decisions. Both use the counts from before the clock edge, so space that
  // an exit frees in this cycle cannot be used by an entry in the same cycle.
  always_comb begin
    res_inc        = 1'b0;
    res_dec        = 1'b0;
    spill_inc      = 1'b0;
    spill_dec      = 1'b0;
    gen_inc        = 1'b0;
    gen_dec        = 1'b0;
    entry_ack_d    = 1'b0;
    entry_reject_d = 1'b0;
    exit_err_d     = 1'b0;

    if (bus.car_entered) begin
      if (bus.is_uni_car_entered) begin
        if (uni_free) begin
          res_inc     = 1'b1;
          entry_ack_d = 1'b1;
        end else if ((SPILL_EN != 0) && gen_free) begin
          spill_inc   = 1'b1;
          entry_ack_d = 1'b1;
        end else begin
          entry_reject_d = 1'b1;
        end
      end else if (gen_free) begin
        gen_inc     = 1'b1;
        entry_ack_d = 1'b1;
      end else begin
        entry_reject_d = 1'b1;
      end
    end

    if (bus.car_exited) begin
      if (bus.is_uni_car_exited) begin
        // Spilled cars leave first so the general pool is released as early as possible.
        if (uni_spill_cnt_q != '0) begin
          spill_dec = 1'b1;
        end else if (uni_res_cnt_q != '0) begin
          res_dec = 1'b1;
        end else begin
          exit_err_d = 1'b1;
        end
      end else if (gen_cnt_q != '0) begin
        gen_dec = 1'b1;
      end else begin
        exit_err_d = 1'b1;
      end
    end
  end

  // Counter next state. An increment and a decrement of the same counter cancel out.
  always_comb begin
    uni_res_cnt_d   = uni_res_cnt_q + cnt_t'(res_inc) - cnt_t'(res_dec);
    uni_spill_cnt_d = uni_spill_cnt_q + cnt_t'(spill_inc) - cnt_t'(spill_dec);
    gen_cnt_d       = gen_cnt_q + cnt_t'(gen_inc) - cnt_t'(gen_dec);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uni_res_cnt_q   <= '0;
      uni_spill_cnt_q <= '0;
      gen_cnt_q       <= '0;
      hour_q          <= '0;
      hour_err_q      <= 1'b0;
      entry_ack_q     <= 1'b0;
      entry_reject_q  <= 1'b0;
      exit_err_q      <= 1'b0;
    end else begin
      uni_res_cnt_q   <= uni_res_cnt_d;
      uni_spill_cnt_q <= uni_spill_cnt_d;
      gen_cnt_q       <= gen_cnt_d;
      hour_q          <= hour_d;
      hour_err_q      <= hour_err_d;
      entry_ack_q     <= entry_ack_d;
      entry_reject_q  <= entry_reject_d;
      exit_err_q      <= exit_err_d;
    end
  end

  assign bus.uni_parked_car       = uni_res_cnt_q + uni_spill_cnt_q;
  assign bus.parked_car           = gen_cnt_q;
  assign bus.uni_spill_car        = uni_spill_cnt_q;
  assign bus.uni_vacated_space    = uni_vac;
  assign bus.vacated_space        = gen_vac;
  assign bus.uni_is_vacated_space = uni_free;
  assign bus.is_vacated_space     = gen_free;
  assign bus.entry_ack            = entry_ack_q;
  assign bus.entry_reject         = entry_reject_q;
  assign bus.exit_err             = exit_err_q;
  assign bus.hour_err             = hour_err_q;

endmodule
